// File: rtl/bin2bcd_if.sv
// Handshake/result bundle between a requester and the binary-to-BCD converter.
// master drives the request; slave (the converter) drives status and results.
interface bin2bcd_if #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [IN_W-1:0]       bin;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  overflow;

    modport master (output start, bin, input ready, done, bcd, blank, overflow);
    modport slave  (input start, bin, output ready, done, bcd, blank, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock,
// with leading-zero blank mask and sticky overflow for values >= 10**DIGITS.
module bin2bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic       clk,
    input  logic       rst,
    bin2bcd_if.slave   bus
);
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IN_W-1:0] shreg;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   scr_adj;
    logic            ovf;
    logic [DIGITS-1:0] mask;

    // Every digit gets its add-3 correction in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bin2bcd_add3 u_add3 (.d(scratch[4*g +: 4]), .q(scr_adj[4*g +: 4]));
    end

    // A digit is blanked only when it and every more-significant digit are zero;
    // the ones digit always shows so a zero value still displays "0".
    assign mask[0] = 1'b0;
    for (genvar g = 1; g < DIGITS; g++) begin : g_blank
        assign mask[g] = ~|scratch[BW-1:4*g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            scratch      <= '0;
            ovf          <= 1'b0;
            bus.ready    <= 1'b1;
            bus.done     <= 1'b0;
            bus.bcd      <= '0;
            bus.overflow <= 1'b0;
            bus.blank    <= ~DIGITS'(1);
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg     <= bus.bin;
                        scratch   <= '0;
                        ovf       <= 1'b0;
                        cnt       <= CW'(IN_W - 1);
                        bus.ready <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The bit leaving the top digit is a lost 10**DIGITS multiple.
                    {scratch, shreg} <= {scr_adj[BW-2:0], shreg, 1'b0};
                    ovf              <= ovf | scr_adj[BW-1];
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    bus.bcd      <= scratch;
                    bus.overflow <= ovf;
                    bus.blank    <= mask;
                    bus.done     <= 1'b1;
                    bus.ready    <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench: 5-digit and 4-digit converters driven in lockstep from a
// vector table, plus hand sequences for ignored start and mid-conversion reset.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin2bcd_if #(.IN_W(16), .DIGITS(5)) if5 ();
    bin2bcd_if #(.IN_W(16), .DIGITS(4)) if4 ();

    bin2bcd_seq #(.IN_W(16), .DIGITS(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));
    bin2bcd_seq #(.IN_W(16), .DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd5;
        logic [4:0]  blank5;
        logic        ovf5;
        logic [15:0] bcd4;
        logic [3:0]  blank4;
        logic        ovf4;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Both converters get the same start/bin; returns edges from start edge to done.
    task automatic convert(input logic [15:0] v, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!if5.ready && g < 50) begin @(negedge clk); g++; end
        if5.start = 1'b1; if5.bin = v;
        if4.start = 1'b1; if4.bin = v;
        @(posedge clk); #1;
        if5.start = 1'b0; if4.start = 1'b0;
        lat = 0;
        while (!if5.done && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    // Protocol monitors: done is a single-cycle pulse, every nibble is a decimal digit.
    logic done5_q = 1'b0, done4_q = 1'b0;
    always @(posedge clk) begin
        done5_q <= if5.done;
        done4_q <= if4.done;
    end
    always @(negedge clk) begin
        assert (!(if5.done && done5_q) && !(if4.done && done4_q)) else begin
            nerr++;
            $display("FAIL done_pulse: done high two cycles in a row");
        end
        for (int d = 0; d < 5; d++)
            assert (if5.bcd[4*d +: 4] <= 4'd9) else begin
                nerr++;
                $display("FAIL nibble5[%0d]: got %0h expected <= 9", d, if5.bcd[4*d +: 4]);
            end
        for (int d = 0; d < 4; d++)
            assert (if4.bcd[4*d +: 4] <= 4'd9) else begin
                nerr++;
                $display("FAIL nibble4[%0d]: got %0h expected <= 9", d, if4.bcd[4*d +: 4]);
            end
    end

    initial begin
        vec_t vt[9];
        int lat, ndone, first, rdy_bad;
        logic [19:0] got;

        vt[0] = '{16'd65535, 20'h65535, 5'b00000, 1'b0, 16'h5535, 4'b0000, 1'b1};
        vt[1] = '{16'd1234,  20'h01234, 5'b10000, 1'b0, 16'h1234, 4'b0000, 1'b0};
        vt[2] = '{16'd0,     20'h00000, 5'b11110, 1'b0, 16'h0000, 4'b1110, 1'b0};
        vt[3] = '{16'd12345, 20'h12345, 5'b00000, 1'b0, 16'h2345, 4'b0000, 1'b1};
        vt[4] = '{16'd9999,  20'h09999, 5'b10000, 1'b0, 16'h9999, 4'b0000, 1'b0};
        vt[5] = '{16'd42,    20'h00042, 5'b11100, 1'b0, 16'h0042, 4'b1100, 1'b0};
        vt[6] = '{16'd7,     20'h00007, 5'b11110, 1'b0, 16'h0007, 4'b1110, 1'b0};
        vt[7] = '{16'd10000, 20'h10000, 5'b00000, 1'b0, 16'h0000, 4'b1110, 1'b1};
        vt[8] = '{16'd100,   20'h00100, 5'b11000, 1'b0, 16'h0100, 4'b1000, 1'b0};

        rst = 1'b1;
        if5.start = 1'b0; if5.bin = '0;
        if4.start = 1'b0; if4.bin = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", if5.ready, 1);
        chk("rst_done", if5.done, 0);
        chk("rst_bcd", if5.bcd, 0);
        chk("rst_blank", if5.blank, 5'b11110);
        chk("rst_ovf", if5.overflow, 0);
        chk("rst_blank4", if4.blank, 4'b1110);
        rst = 1'b0;

        foreach (vt[i]) begin
            convert(vt[i].bin, lat);
            chk($sformatf("lat[%0d]", i), lat, 17);
            chk($sformatf("ready_at_done[%0d]", i), if5.ready, 1);
            chk($sformatf("bcd5[%0d]", i), if5.bcd, vt[i].bcd5);
            chk($sformatf("blank5[%0d]", i), if5.blank, vt[i].blank5);
            chk($sformatf("ovf5[%0d]", i), if5.overflow, vt[i].ovf5);
            chk($sformatf("bcd4[%0d]", i), if4.bcd, vt[i].bcd4);
            chk($sformatf("blank4[%0d]", i), if4.blank, vt[i].blank4);
            chk($sformatf("ovf4[%0d]", i), if4.overflow, vt[i].ovf4);
        end

        // Start pulsed mid-conversion must be ignored.
        @(negedge clk);
        if5.start = 1'b1; if5.bin = 16'd42;
        @(posedge clk); #1;
        if5.start = 1'b0;
        ndone = 0; first = 0; rdy_bad = 0; got = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (if5.done) begin
                ndone++;
                if (first == 0) first = c;
                got = if5.bcd;
            end else if (first == 0 && if5.ready) rdy_bad++;
            if (c == 5) begin if5.start = 1'b1; if5.bin = 16'd999; end
            else if (c == 6) if5.start = 1'b0;
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_lat", first, 17);
        chk("ign_bcd", got, 20'h00042);
        chk("ign_ready_low", rdy_bad, 0);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        if5.start = 1'b1; if5.bin = 16'd777;
        @(posedge clk); #1;
        if5.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", if5.ready, 1);
        chk("mid_rst_bcd", if5.bcd, 0);
        chk("mid_rst_blank", if5.blank, 5'b11110);
        chk("mid_rst_ovf", if5.overflow, 0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (if5.done) ndone++;
        end
        chk("mid_rst_nodone", ndone, 0);

        convert(16'd31, lat);
        chk("post_rst_lat", lat, 17);
        chk("post_rst_bcd", if5.bcd, 20'h00031);
        chk("post_rst_blank", if5.blank, 5'b11100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
